// File: rtl/riscv_core_fwd_sel_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_core_fwd_sel_pipe: registered N:1 operand select with 2-entry skid |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module riscv_core_fwd_sel_pipe #(
  parameter  int XLEN     = 64,
  parameter  int NUM_IN   = 4,
  parameter  int SEL_MODE = 0,
  localparam int SELW     = (SEL_MODE != 0) ? NUM_IN : $clog2(NUM_IN)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic [NUM_IN*XLEN-1:0] i_in_data,
  input  logic [SELW-1:0]        i_in_sel,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic [XLEN-1:0]        o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_sel_err
);

  logic [XLEN-1:0] w_dec_data;
  logic            w_dec_err;
  logic            w_accept;
  logic            w_transfer;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_data;
  logic            r_out_err;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_data;
  logic            r_skid_err;

  if (SEL_MODE == 0) begin : g_bin_dec
    // Unmatched indices (sel >= NUM_IN) fall through to the zero/error default.
    always_comb begin
      w_dec_data = '0;
      w_dec_err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
        if (i_in_sel == SELW'(k)) begin
          w_dec_data = i_in_data[k*XLEN +: XLEN];
          w_dec_err  = 1'b0;
        end
      end
    end
  end else begin : g_onehot_dec
    logic            w_seen;
    logic            w_multi;
    logic [XLEN-1:0] w_acc;

    always_comb begin
      w_seen  = 1'b0;
      w_multi = 1'b0;
      w_acc   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        if (i_in_sel[k]) begin
          w_multi = w_multi | w_seen;
          w_seen  = 1'b1;
          w_acc   = w_acc | i_in_data[k*XLEN +: XLEN];
        end
      end
      w_dec_err  = ~w_seen | w_multi;
      w_dec_data = w_dec_err ? '0 : w_acc;
    end
  end

  assign w_accept   = i_in_valid & ~r_skid_valid;
  assign w_transfer = r_out_valid & i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      // FULL: ready is low, so only a drain can happen.
      if (w_transfer) begin
        r_out_data   <= r_skid_data;
        r_out_err    <= r_skid_err;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid || w_transfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_dec_data;
        r_out_err   <= w_dec_err;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_dec_data;
        r_skid_err   <= w_dec_err;
      end
    end else if (w_transfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = ~r_skid_valid;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_sel_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_fwd_sel_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_core_fwd_sel_pipe: directed vectors for the operand select pipe |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_riscv_core_fwd_sel_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // m_: 4-input binary, t_: 3-input binary, h_: 4-input one-hot
  logic [4*64-1:0] m_data;
  logic [3*64-1:0] t_data;
  logic [4*64-1:0] h_data;
  logic [1:0] m_sel = '0, t_sel = '0;
  logic [3:0] h_sel = '0;
  logic m_valid = 0, t_valid = 0, h_valid = 0;
  logic m_oready = 1, t_oready = 1, h_oready = 1;
  logic m_iready, t_iready, h_iready;
  logic m_ovalid, t_ovalid, h_ovalid;
  logic m_err, t_err, h_err;
  logic [63:0] m_out, t_out, h_out;

  initial begin
    for (int k = 0; k < 4; k++) m_data[k*64 +: 64] = 64'(k + 'h10);
    for (int k = 0; k < 3; k++) t_data[k*64 +: 64] = 64'(k + 'h10);
    for (int k = 0; k < 4; k++) h_data[k*64 +: 64] = 64'(k + 'h10);
  end

  riscv_core_fwd_sel_pipe #(.XLEN(64), .NUM_IN(4), .SEL_MODE(0)) u_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_data(m_data),
    .i_in_sel(m_sel), .i_in_valid(m_valid), .o_in_ready(m_iready),
    .o_out_data(m_out), .o_out_valid(m_ovalid), .i_out_ready(m_oready),
    .o_sel_err(m_err));

  riscv_core_fwd_sel_pipe #(.XLEN(64), .NUM_IN(3), .SEL_MODE(0)) u_t (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_data(t_data),
    .i_in_sel(t_sel), .i_in_valid(t_valid), .o_in_ready(t_iready),
    .o_out_data(t_out), .o_out_valid(t_ovalid), .i_out_ready(t_oready),
    .o_sel_err(t_err));

  riscv_core_fwd_sel_pipe #(.XLEN(64), .NUM_IN(4), .SEL_MODE(1)) u_h (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_data(h_data),
    .i_in_sel(h_sel), .i_in_valid(h_valid), .o_in_ready(h_iready),
    .o_out_data(h_out), .o_out_valid(h_ovalid), .i_out_ready(h_oready),
    .o_sel_err(h_err));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         dut;
    logic [3:0] sel;
    logic [63:0] data;
    logic       err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic av, ae, ar;
    logic [63:0] ad;

    vecs[0]  = '{0, 4'd2, 64'h12, 1'b0};
    vecs[1]  = '{0, 4'd0, 64'h10, 1'b0};
    vecs[2]  = '{0, 4'd1, 64'h11, 1'b0};
    vecs[3]  = '{0, 4'd2, 64'h12, 1'b0};
    vecs[4]  = '{0, 4'd3, 64'h13, 1'b0};
    vecs[5]  = '{1, 4'd0, 64'h10, 1'b0};
    vecs[6]  = '{1, 4'd2, 64'h12, 1'b0};
    vecs[7]  = '{1, 4'd3, 64'h0,  1'b1};
    vecs[8]  = '{1, 4'd1, 64'h11, 1'b0};
    vecs[9]  = '{2, 4'b0001, 64'h10, 1'b0};
    vecs[10] = '{2, 4'b1000, 64'h13, 1'b0};
    vecs[11] = '{2, 4'b0110, 64'h0,  1'b1};
    vecs[12] = '{2, 4'b0100, 64'h12, 1'b0};
    vecs[13] = '{2, 4'b0000, 64'h0,  1'b1};
    vecs[14] = '{2, 4'b1111, 64'h0,  1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(m_ovalid), 64'd0);
    chk("rst_data",  m_out, 64'd0);
    chk("rst_err",   64'(m_err), 64'd0);
    chk("rst_ready", 64'(m_iready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one beat per cycle, downstream always ready
    foreach (vecs[i]) begin
      @(negedge clk);
      m_valid = 0; t_valid = 0; h_valid = 0;
      case (vecs[i].dut)
        0: begin m_valid = 1; m_sel = vecs[i].sel[1:0]; end
        1: begin t_valid = 1; t_sel = vecs[i].sel[1:0]; end
        default: begin h_valid = 1; h_sel = vecs[i].sel; end
      endcase
      @(posedge clk);
      #1;
      case (vecs[i].dut)
        0: begin av = m_ovalid; ad = m_out; ae = m_err; ar = m_iready; end
        1: begin av = t_ovalid; ad = t_out; ae = t_err; ar = t_iready; end
        default: begin av = h_ovalid; ad = h_out; ae = h_err; ar = h_iready; end
      endcase
      chk($sformatf("vec%0d_valid", i), 64'(av), 64'd1);
      chk($sformatf("vec%0d_data", i), ad, vecs[i].data);
      chk($sformatf("vec%0d_err", i), 64'(ae), 64'(vecs[i].err));
      chk($sformatf("vec%0d_ready", i), 64'(ar), 64'd1);
    end
    @(negedge clk);
    m_valid = 0; t_valid = 0; h_valid = 0;
    @(posedge clk); #1;
    chk("drain_valid", 64'(h_ovalid), 64'd0);

    // Backpressure: A held, B in skid, drained in order
    @(negedge clk);
    m_oready = 0; m_valid = 1; m_sel = 2'd1;
    @(negedge clk);
    chk("bp_a_data", m_out, 64'h11);
    chk("bp_a_ready", 64'(m_iready), 64'd1);
    m_sel = 2'd3;
    @(negedge clk);
    m_valid = 0;
    chk("bp_full_ready", 64'(m_iready), 64'd0);
    chk("bp_full_data", m_out, 64'h11);
    @(negedge clk);
    chk("bp_hold_data", m_out, 64'h11);
    chk("bp_hold_valid", 64'(m_ovalid), 64'd1);
    m_oready = 1;
    @(posedge clk); #1;
    chk("bp_b_data", m_out, 64'h13);
    chk("bp_b_valid", 64'(m_ovalid), 64'd1);
    chk("bp_b_ready", 64'(m_iready), 64'd1);
    @(posedge clk); #1;
    chk("bp_empty", 64'(m_ovalid), 64'd0);

    // Skid carrying an error beat (3-input, sel=3)
    @(negedge clk);
    t_oready = 0; t_valid = 1; t_sel = 2'd0;
    @(negedge clk);
    t_sel = 2'd3;
    @(negedge clk);
    t_valid = 0;
    chk("skid_err_first", 64'(t_err), 64'd0);
    t_oready = 1;
    @(posedge clk); #1;
    chk("skid_err_data", t_out, 64'd0);
    chk("skid_err_bit", 64'(t_err), 64'd1);
    chk("skid_err_valid", 64'(t_ovalid), 64'd1);

    // Flush from FULL with a same-cycle beat
    @(negedge clk);
    m_oready = 0; m_valid = 1; m_sel = 2'd0;
    @(negedge clk);
    m_sel = 2'd1;
    @(negedge clk);
    chk("fl_pre_ready", 64'(m_iready), 64'd0);
    flush = 1; m_sel = 2'd2;
    @(negedge clk);
    flush = 0; m_valid = 0;
    chk("fl_valid", 64'(m_ovalid), 64'd0);
    chk("fl_ready", 64'(m_iready), 64'd1);
    m_oready = 1;
    @(posedge clk); #1;
    chk("fl_no_beat", 64'(m_ovalid), 64'd0);

    // Async reset mid-stream, then latency 1 after release
    @(negedge clk);
    m_valid = 1; m_sel = 2'd2;
    @(negedge clk);
    chk("ar_pre_valid", 64'(m_ovalid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", 64'(m_ovalid), 64'd0);
    chk("ar_data", m_out, 64'd0);
    chk("ar_ready", 64'(m_iready), 64'd1);
    @(negedge clk);
    rst_n = 1; m_sel = 2'd3;
    @(posedge clk); #1;
    chk("ar_post_valid", 64'(m_ovalid), 64'd1);
    chk("ar_post_data", m_out, 64'h13);
    m_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
